// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//   Shared constants and types for the SHA-256 round controller and the
//   compression datapath it drives.
//   Contents: FSM state encoding, round/message-word counts, counter width,
//   and the standard initial hash values H0..H7.
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int SHA_ROUNDS    = 64;
    localparam int SHA_MSG_WORDS = 16;
    localparam int SHA_IDX_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Initial hash value loaded into H0..H7 at the start of a message.
    localparam logic [31:0] SHA_H0 = 32'h6a09e667;
    localparam logic [31:0] SHA_H1 = 32'hbb67ae85;
    localparam logic [31:0] SHA_H2 = 32'h3c6ef372;
    localparam logic [31:0] SHA_H3 = 32'ha54ff53a;
    localparam logic [31:0] SHA_H4 = 32'h510e527f;
    localparam logic [31:0] SHA_H5 = 32'h9b05688c;
    localparam logic [31:0] SHA_H6 = 32'h1f83d9ab;
    localparam logic [31:0] SHA_H7 = 32'h5be0cd19;

endpackage : sha256_pkg

// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//   Sequencer for the SHA-256 compression datapath. Accepts one padded
//   512-bit block per handshake, walks it through INIT, ROUNDS compression
//   rounds and an accumulate step, chains multi-block messages and pulses
//   o_digest_valid after the last block of a message.
//
//   Handshake: a block is taken on the rising edge where i_blk_valid and
//   o_blk_ready are both high. o_blk_ready is high only in IDLE with i_abort
//   low (and never during reset); i_first_blk/i_last_blk are sampled on that
//   same edge. Upstream may hold i_blk_valid high; blocks are then taken
//   back-to-back whenever the controller returns to IDLE.
//
// Ports
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_blk_valid        upstream holds a complete padded block
//   o_blk_ready        controller can accept a block
//   i_first_blk        block starts a new message
//   i_last_blk         block ends the message
//   i_abort            synchronous abort of the current block/message
//   o_k_addr           round index to the K constant table (0 outside ROUND)
//   o_w_load           round consumes message word o_w_idx directly
//   o_w_idx            message word index, round[3:0]
//   o_hv_init          load IV into H0..H7 (and a..h together with o_wv_load)
//   o_wv_load          load working variables a..h from H0..H7
//   o_round_en         perform one compression round
//   o_hv_accum         H_i <= H_i + working variable
//   o_digest_valid     one-cycle pulse: H0..H7 hold the final digest
//   o_busy             controller is not IDLE
//   o_chain_err        one-cycle pulse: continuation block with no open chain
//   o_state            current FSM state (debug)
// ---------------------------------------------------------------------------
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS    = SHA_ROUNDS,
    parameter int MSG_WORDS = SHA_MSG_WORDS,
    parameter int IDX_W     = SHA_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic             i_first_blk,
    input  logic             i_last_blk,
    input  logic             i_abort,
    output logic [IDX_W-1:0] o_k_addr,
    output logic             o_w_load,
    output logic [3:0]       o_w_idx,
    output logic             o_hv_init,
    output logic             o_wv_load,
    output logic             o_round_en,
    output logic             o_hv_accum,
    output logic             o_digest_valid,
    output logic             o_busy,
    output logic             o_chain_err,
    output state_t           o_state
);

    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] MSG_LIMIT  = IDX_W'(MSG_WORDS);

    state_t           r_state;
    logic [IDX_W-1:0] r_round;
    logic             r_chain_open;
    logic             r_last_q;
    logic             r_wv_load;
    logic             r_hv_init;
    logic             r_round_en;
    logic             r_w_load;
    logic             r_hv_accum;
    logic             r_digest_valid;
    logic             r_chain_err;

    logic             w_handshake;
    logic             w_last_round;
    logic [IDX_W-1:0] w_round_nxt;

    // Reset is folded in so the port reads 0 while reset is held, even
    // though the state register already sits in IDLE.
    assign o_blk_ready  = (r_state == ST_IDLE) && !i_abort && !i_rst;
    assign w_handshake  = i_blk_valid && o_blk_ready;
    assign w_last_round = (r_round == LAST_ROUND);
    assign w_round_nxt  = r_round + 1'b1;

    // Strobes are registered and set on the edge that enters their state,
    // so each one is high exactly for the cycle spent in that state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_round        <= '0;
            r_chain_open   <= 1'b0;
            r_last_q       <= 1'b0;
            r_wv_load      <= 1'b0;
            r_hv_init      <= 1'b0;
            r_round_en     <= 1'b0;
            r_w_load       <= 1'b0;
            r_hv_accum     <= 1'b0;
            r_digest_valid <= 1'b0;
            r_chain_err    <= 1'b0;
        end else begin
            // Single-cycle strobes default low every cycle.
            r_wv_load      <= 1'b0;
            r_hv_init      <= 1'b0;
            r_hv_accum     <= 1'b0;
            r_digest_valid <= 1'b0;
            r_chain_err    <= 1'b0;

            if (i_abort) begin
                // Drop the block and the whole message; nothing is accumulated.
                r_state      <= ST_IDLE;
                r_round      <= '0;
                r_chain_open <= 1'b0;
                r_round_en   <= 1'b0;
                r_w_load     <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_handshake) begin
                            r_state   <= ST_INIT;
                            r_last_q  <= i_last_blk;
                            r_wv_load <= 1'b1;
                            // A continuation block with no open chain is
                            // treated as the start of a new message.
                            r_hv_init   <= i_first_blk || !r_chain_open;
                            r_chain_err <= !i_first_blk && !r_chain_open;
                        end
                    end
                    ST_INIT: begin
                        r_state      <= ST_ROUND;
                        r_chain_open <= 1'b1;
                        r_round_en   <= 1'b1;
                        r_w_load     <= (r_round < MSG_LIMIT);
                    end
                    ST_ROUND: begin
                        if (w_last_round) begin
                            r_state    <= ST_ACCUM;
                            r_round    <= '0;
                            r_round_en <= 1'b0;
                            r_w_load   <= 1'b0;
                            r_hv_accum <= 1'b1;
                        end else begin
                            r_round  <= w_round_nxt;
                            r_w_load <= (w_round_nxt < MSG_LIMIT);
                        end
                    end
                    ST_ACCUM: begin
                        if (r_last_q) begin
                            r_state        <= ST_DONE;
                            r_digest_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        r_state      <= ST_IDLE;
                        r_chain_open <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The round counter is 0 outside ROUND, so it doubles as the K address.
    assign o_k_addr       = r_round;
    assign o_w_idx        = r_round[3:0];
    assign o_w_load       = r_w_load;
    assign o_hv_init      = r_hv_init;
    assign o_wv_load      = r_wv_load;
    assign o_round_en     = r_round_en;
    assign o_hv_accum     = r_hv_accum;
    assign o_digest_valid = r_digest_valid;
    assign o_chain_err    = r_chain_err;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_state        = r_state;

endmodule : sha256_round_ctrl

// File: tb/tb_sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_ctrl
//   Directed bench for the SHA-256 round controller. Cycle 0 of each test is
//   the cycle whose closing edge carries the handshake; outputs are sampled on
//   the falling edge in the middle of each cycle.
// ---------------------------------------------------------------------------
module tb_sha256_round_ctrl;
    import sha256_pkg::*;

    typedef logic [18:0] ov_t;

    typedef struct {
        string name;
        int    cyc;
        bit    rdy;
        bit    bsy;
        bit    wv;
        bit    hi;
        bit    ren;
        int    k;
        bit    wl;
        int    widx;
        bit    acc;
        bit    dv;
        bit    ce;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       blk_valid;
    logic       blk_ready;
    logic       first_blk;
    logic       last_blk;
    logic       abort;
    logic [5:0] k_addr;
    logic       w_load;
    logic [3:0] w_idx;
    logic       hv_init;
    logic       wv_load;
    logic       round_en;
    logic       hv_accum;
    logic       digest_valid;
    logic       busy;
    logic       chain_err;
    state_t     dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_blk_valid    (blk_valid),
        .o_blk_ready    (blk_ready),
        .i_first_blk    (first_blk),
        .i_last_blk     (last_blk),
        .i_abort        (abort),
        .o_k_addr       (k_addr),
        .o_w_load       (w_load),
        .o_w_idx        (w_idx),
        .o_hv_init      (hv_init),
        .o_wv_load      (wv_load),
        .o_round_en     (round_en),
        .o_hv_accum     (hv_accum),
        .o_digest_valid (digest_valid),
        .o_busy         (busy),
        .o_chain_err    (chain_err),
        .o_state        (dbg_state)
    );

    // ---------------- helpers ----------------
    function automatic ov_t mk(bit rdy, bit bsy, bit wv, bit hi, bit ren, int k,
                               bit wl, int widx, bit acc, bit dv, bit ce);
        return {rdy, bsy, wv, hi, ren, 6'(k), wl, 4'(widx), acc, dv, ce};
    endfunction

    function automatic ov_t pack();
        return {blk_ready, busy, wv_load, hv_init, round_en, k_addr,
                w_load, w_idx, hv_accum, digest_valid, chain_err};
    endfunction

    localparam ov_t IDLE_V = 19'h40000;  // blk_ready only

    // Expected outputs c cycles after a handshake cycle (c=0).
    function automatic ov_t exp_vec(int c, bit hi, bit last, bit ce);
        int r;
        if (c == 0) return IDLE_V;
        if (c == 1) return mk(0, 1, 1, hi, 0, 0, 0, 0, 0, 0, ce);
        if (c >= 2 && c <= 65) begin
            r = c - 2;
            return mk(0, 1, 0, 0, 1, r, (r < 16), r % 16, 0, 0, 0);
        end
        if (c == 66) return mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (c == 67 && last) return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        return IDLE_V;
    endfunction

    task automatic check(input string name, input ov_t act, input ov_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit f, input bit l, input bit a);
        blk_valid = v;
        first_blk = f;
        last_blk  = l;
        abort     = a;
    endtask

    // Two blocks, handshakes at c0 and c67; first block opens a chain.
    task automatic run_pair(input string tag, input bit f2, input bit exp_hi2);
        ov_t e;
        for (int i = 0; i <= 136; i++) begin
            @(posedge clk); #1;
            drive((i == 0 || i == 67), (i < 67) ? 1'b1 : f2, (i >= 67), 1'b0);
            @(negedge clk);
            e = (i < 67) ? exp_vec(i, 1, 0, 0) : exp_vec(i - 67, exp_hi2, 1, 0);
            check($sformatf("%s_c%0d", tag, i), pack(), e);
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[10];

    initial begin
        ov_t e;
        int  dv_cnt;

        tbl[0] = '{"t1_c0_idle",   0, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};
        tbl[1] = '{"t1_c1_init",   1, 0, 1, 1, 1, 0,  0, 0,  0, 0, 0, 0};
        tbl[2] = '{"t1_c2_r0",     2, 0, 1, 0, 0, 1,  0, 1,  0, 0, 0, 0};
        tbl[3] = '{"t1_c17_r15",  17, 0, 1, 0, 0, 1, 15, 1, 15, 0, 0, 0};
        tbl[4] = '{"t1_c18_r16",  18, 0, 1, 0, 0, 1, 16, 0,  0, 0, 0, 0};
        tbl[5] = '{"t1_c40_r38",  40, 0, 1, 0, 0, 1, 38, 0,  6, 0, 0, 0};
        tbl[6] = '{"t1_c65_r63",  65, 0, 1, 0, 0, 1, 63, 0, 15, 0, 0, 0};
        tbl[7] = '{"t1_c66_acc",  66, 0, 1, 0, 0, 0,  0, 0,  0, 1, 0, 0};
        tbl[8] = '{"t1_c67_dv",   67, 0, 1, 0, 0, 0,  0, 0,  0, 0, 1, 0};
        tbl[9] = '{"t1_c68_idle", 68, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_outputs", pack(), '0);
        check("rst_state", ov_t'(dbg_state), ov_t'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", pack(), IDLE_V);

        // Test 1: single block, hand-computed checkpoints.
        begin
            ov_t got[0:69];
            for (int i = 0; i <= 69; i++) begin
                @(posedge clk); #1;
                drive((i == 0), 1, 1, 0);
                @(negedge clk);
                got[i] = pack();
            end
            for (int j = 0; j < 10; j++) begin
                e = mk(tbl[j].rdy, tbl[j].bsy, tbl[j].wv, tbl[j].hi, tbl[j].ren,
                       tbl[j].k, tbl[j].wl, tbl[j].widx, tbl[j].acc, tbl[j].dv, tbl[j].ce);
                check(tbl[j].name, got[tbl[j].cyc], e);
            end
            for (int i = 0; i <= 69; i++)
                check($sformatf("t1_sweep_c%0d", i), got[i], exp_vec(i, 1, 1, 0));
        end

        // Test 2: two-block chain, continuation block keeps H.
        run_pair("t2", 1'b0, 1'b0);

        // Test 7: first_blk on an open chain restarts it silently.
        run_pair("t7", 1'b1, 1'b1);

        // Test 3: abort at k_addr=30, then a continuation block with no chain.
        for (int i = 0; i <= 109; i++) begin
            @(posedge clk); #1;
            if (i < 40) drive((i == 0), 1, 1, (i == 32));
            else        drive((i == 40), 0, 1, 0);
            @(negedge clk);
            if (i <= 32)     e = exp_vec(i, 1, 1, 0);
            else if (i < 40) e = IDLE_V;
            else             e = exp_vec(i - 40, 1, 1, 1);
            check($sformatf("t3_c%0d", i), pack(), e);
            if (i == 33)
                check("t3_state_after_abort", ov_t'(dbg_state), ov_t'(ST_IDLE));
        end

        // Test 5: blk_valid held high across three blocks.
        dv_cnt = 0;
        for (int i = 0; i <= 203; i++) begin
            @(posedge clk); #1;
            if (i < 67)       drive(1, 1, 0, 0);
            else if (i < 134) drive(1, 0, 0, 0);
            else              drive((i == 134), 0, 1, 0);
            @(negedge clk);
            if (i < 67)       e = exp_vec(i, 1, 0, 0);
            else if (i < 134) e = exp_vec(i - 67, 0, 0, 0);
            else              e = exp_vec(i - 134, 0, 1, 0);
            check($sformatf("t5_c%0d", i), pack(), e);
            if (digest_valid) dv_cnt++;
        end
        check("t5_digest_count", ov_t'(dv_cnt), ov_t'(1));

        // Test 6: abort wins over blk_valid in IDLE.
        @(posedge clk); #1;
        drive(1, 1, 1, 1);
        @(negedge clk);
        check("t6_abort_ready_low", pack(), '0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t6_no_handshake", pack(), IDLE_V);

        // Test 4: asynchronous reset at k_addr=40.
        for (int i = 0; i <= 41; i++) begin
            @(posedge clk); #1;
            drive((i == 0), 1, 1, 0);
            @(negedge clk);
            check($sformatf("t4_c%0d", i), pack(), exp_vec(i, 1, 1, 0));
        end
        @(posedge clk); #1;
        check("t4_c42_k40", pack(), exp_vec(42, 1, 1, 0));
        rst = 1'b1;
        #1;
        check("t4_async_rst", pack(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_release", pack(), IDLE_V);
        // Reset closed the chain, so a continuation block flags chain_err.
        for (int i = 0; i <= 69; i++) begin
            @(posedge clk); #1;
            drive((i == 0), 0, 1, 0);
            @(negedge clk);
            check($sformatf("t4_post_c%0d", i), pack(), exp_vec(i, 1, 1, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_sha256_round_ctrl
